lsu_access: RTL and testbench

LSU_ACCESS -- requirements
Module: lsu_access

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/lsu_load_align.sv | 34 +++
 rtl/lsu_access.sv | 203 ++++++++++++++++++++
 tb/tb_lsu_access.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and types for the load/store access unit.
//   - RISC-V opcode values for loads and stores
//   - funct3 width encodings
//   - FSM state type, access-size type, AXI response codes
//   - helpers that classify access width and alignment
package lsu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WADDR,
        WRESP,
        DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } acc_size_t;

    // Anything that is not a recognised byte/halfword encoding is a word
    // access; the unsigned variants only exist for loads.
    function automatic acc_size_t access_size(input logic is_load, input logic [2:0] f3);
        if (f3 == F3_B || (is_load && f3 == F3_BU)) return SZ_BYTE;
        if (f3 == F3_H || (is_load && f3 == F3_HU)) return SZ_HALF;
        return SZ_WORD;
    endfunction

    function automatic logic misaligned(input acc_size_t sz, input logic [1:0] off);
        case (sz)
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load-data extraction.
//   word    : 32-bit bus word as returned by the read channel
//   funct3  : load width/sign encoding
//   offset  : byte offset of the effective address within the word
//   is_load : result is forced to zero when the op is not a load
//   data    : aligned, sign/zero-extended load result
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic        is_load,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        data    = '0;
        if (is_load) begin
            case (funct3)
                F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
                F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
                F3_BU:   data = {24'h0, shifted[7:0]};
                F3_HU:   data = {16'h0, shifted[15:0]};
                F3_W:    data = shifted;
                default: data = shifted;
            endcase
        end
    end

endmodule

// File: rtl/lsu_access.sv
// lsu_access: single-outstanding load/store unit with an AXI4-Lite master.
//   Upstream : valid_in_exu / ready_out_lsu handshake, instruction fields
//              latched on accept (opcode, funct3, pc, aluout, store_data,
//              gpr_wen, rd).
//   AXI      : AR/R for loads, AW/W/B for stores; word-aligned addresses,
//              byte lanes selected through wstrb.
//   Result   : valid_out_lsu one-cycle pulse with registered copies of the
//              instruction fields, aligned load data (rdata_w) and acc_fault
//              for a non-OKAY response.
// Build option: define LSU_MISALIGN_TRAP_EN to turn misaligned halfword/word
//   accesses into an immediate fault with no bus traffic.
module lsu_access
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in_exu,
    output logic        ready_out_lsu,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] pc,
    input  logic [31:0] aluout,
    input  logic [31:0] store_data,
    input  logic        gpr_wen,
    input  logic [4:0]  rd,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic        valid_out_lsu,
    output logic [6:0]  opcode_o,
    output logic [31:0] pc_o,
    output logic [31:0] aluout_o,
    output logic        gpr_wen_o,
    output logic [4:0]  rd_o,
    output logic [31:0] rdata_w,
    output logic        acc_fault
);

    lsu_state_t  state, state_nxt;

    logic [6:0]  opcode_q;
    logic [2:0]  funct3_q;
    logic [31:0] pc_q;
    logic [31:0] aluout_q;
    logic [31:0] store_data_q;
    logic        gpr_wen_q;
    logic [4:0]  rd_q;
    logic [31:0] rdata_q;
    logic        fault_q;
    logic        aw_done;
    logic        w_done;

    logic        accept;
    logic        trap_in;

    assign accept = (state == IDLE) && valid_in_exu;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_in = (opcode == OPC_LOAD || opcode == OPC_STORE) &&
                     misaligned(access_size(opcode == OPC_LOAD, funct3), aluout[1:0]);
`else
    assign trap_in = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        ready_out_lsu = 1'b0;
        arvalid       = 1'b0;
        rready        = 1'b0;
        awvalid       = 1'b0;
        wvalid        = 1'b0;
        bready        = 1'b0;
        valid_out_lsu = 1'b0;
        acc_fault     = 1'b0;
        case (state)
            IDLE: begin
                ready_out_lsu = 1'b1;
                if (valid_in_exu) begin
                    if (trap_in)                  state_nxt = DONE;
                    else if (opcode == OPC_LOAD)  state_nxt = RADDR;
                    else if (opcode == OPC_STORE) state_nxt = WADDR;
                    else                          state_nxt = DONE;
                end
            end
            RADDR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = RDATA;
            end
            RDATA: begin
                rready = 1'b1;
                if (rvalid) state_nxt = DONE;
            end
            WADDR: begin
                // Each channel drops its valid once it has handshaken; the
                // phase ends when both have, in whichever order they came.
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready)) state_nxt = WRESP;
            end
            WRESP: begin
                bready = 1'b1;
                if (bvalid) state_nxt = DONE;
            end
            DONE: begin
                valid_out_lsu = 1'b1;
                acc_fault     = fault_q;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opcode_q     <= '0;
            funct3_q     <= '0;
            pc_q         <= '0;
            aluout_q     <= '0;
            store_data_q <= '0;
            gpr_wen_q    <= 1'b0;
            rd_q         <= '0;
            rdata_q      <= '0;
            fault_q      <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
        end else begin
            if (accept) begin
                opcode_q     <= opcode;
                funct3_q     <= funct3;
                pc_q         <= pc;
                aluout_q     <= aluout;
                store_data_q <= store_data;
                gpr_wen_q    <= gpr_wen;
                rd_q         <= rd;
                // Cleared data keeps rdata_w at zero for trapped loads.
                rdata_q      <= '0;
                fault_q      <= trap_in;
                aw_done      <= 1'b0;
                w_done       <= 1'b0;
            end
            if (state == RDATA && rvalid) begin
                rdata_q <= rdata;
                fault_q <= (rresp != RESP_OKAY);
            end
            if (state == WADDR) begin
                if (awvalid && awready) aw_done <= 1'b1;
                if (wvalid && wready)   w_done  <= 1'b1;
            end
            if (state == WRESP && bvalid) fault_q <= (bresp != RESP_OKAY);
        end
    end

    // ---------------- bus-facing outputs ----------------
    // Driven only from latched fields, so they cannot change while a
    // valid is waiting for its ready.
    assign araddr = {aluout_q[31:2], 2'b00};
    assign awaddr = {aluout_q[31:2], 2'b00};
    assign wdata  = store_data_q << {aluout_q[1:0], 3'b000};

    always_comb begin
        case (access_size(1'b0, funct3_q))
            SZ_BYTE: wstrb = 4'b0001 << aluout_q[1:0];
            SZ_HALF: wstrb = 4'b0011 << aluout_q[1:0];
            default: wstrb = 4'b1111;
        endcase
    end

    assign opcode_o  = opcode_q;
    assign pc_o      = pc_q;
    assign aluout_o  = aluout_q;
    assign gpr_wen_o = gpr_wen_q;
    assign rd_o      = rd_q;

    lsu_load_align u_align (
        .word    (rdata_q),
        .funct3  (funct3_q),
        .offset  (aluout_q[1:0]),
        .is_load (opcode_q == OPC_LOAD),
        .data    (rdata_w)
    );

endmodule

// File: tb/tb_lsu_access.sv
// tb_lsu_access: randomized bench for lsu_access with a timeline model.
// The model predicts, from each transaction's fields and the slave delays,
// the exact cycle window of every AXI valid/ready and the completion cycle,
// plus bus payloads and result values from plain arithmetic.
module tb_lsu_access;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in_exu, ready_out_lsu;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] pc, aluout, store_data;
    logic        gpr_wen;
    logic [4:0]  rd;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;
    logic        valid_out_lsu, gpr_wen_o, acc_fault;
    logic [6:0]  opcode_o;
    logic [31:0] pc_o, aluout_o, rdata_w;
    logic [4:0]  rd_o;

    lsu_access dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in_exu(valid_in_exu), .ready_out_lsu(ready_out_lsu),
        .opcode(opcode), .funct3(funct3), .pc(pc), .aluout(aluout),
        .store_data(store_data), .gpr_wen(gpr_wen), .rd(rd),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .valid_out_lsu(valid_out_lsu), .opcode_o(opcode_o), .pc_o(pc_o),
        .aluout_o(aluout_o), .gpr_wen_o(gpr_wen_o), .rd_o(rd_o),
        .rdata_w(rdata_w), .acc_fault(acc_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model state ----------------
    int n_start = 0, n_done = 0, n_abort = 0;
    int na, done_at, m_kind;           // kind: 0 none, 1 load, 2 store, 3 trap
    int m_ar, m_r, m_aw, m_w, m_b;
    logic [31:0] m_addr, m_wdata, m_rdw, m_pc, m_alu, s_rword;
    logic [3:0]  m_wstrb;
    logic [6:0]  m_op;
    logic [4:0]  m_rd;
    logic        m_gpr, m_fault;
    logic [1:0]  s_rresp, s_bresp;
    bit          chk_en = 0;

    function automatic int sz_of(input bit ld, input logic [2:0] f3);
        if (ld) return (f3 == 0 || f3 == 4) ? 1 : ((f3 == 1 || f3 == 5) ? 2 : 4);
        return (f3 == 0) ? 1 : ((f3 == 1) ? 2 : 4);
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] word, input logic [2:0] f3, input int off);
        logic [31:0] w, v;
        w = word >> (8 * off);
        case (sz_of(1, f3))
            1: begin v = w & 32'hFF;   if (f3 == 0 && v >= 128)   v = v + 32'hFFFF_FF00; end
            2: begin v = w & 32'hFFFF; if (f3 == 1 && v >= 32768) v = v + 32'hFFFF_0000; end
            default: v = w;
        endcase
        return v;
    endfunction

    // ---------------- AXI slave with programmed delays ----------------
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    always @(negedge clk) begin
        if (arvalid) begin arready = (ar_cnt >= m_ar); ar_cnt++; end else begin arready = 0; ar_cnt = 0; end
        if (rready)  begin rvalid  = (r_cnt  >= m_r);  r_cnt++;  end else begin rvalid  = 0; r_cnt  = 0; end
        if (awvalid) begin awready = (aw_cnt >= m_aw); aw_cnt++; end else begin awready = 0; aw_cnt = 0; end
        if (wvalid)  begin wready  = (w_cnt  >= m_w);  w_cnt++;  end else begin wready  = 0; w_cnt  = 0; end
        if (bready)  begin bvalid  = (b_cnt  >= m_b);  b_cnt++;  end else begin bvalid  = 0; b_cnt  = 0; end
        rdata = rvalid ? s_rword : $urandom;
        rresp = rvalid ? s_rresp : 2'b11;
        bresp = bvalid ? s_bresp : 2'b11;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            bit act, vo;
            int mx;
            act = (n_start != n_done + n_abort) && (cyc >= na);
            vo  = act && (cyc == done_at);
            mx  = (m_aw > m_w) ? m_aw : m_w;
            chk("valid_out_lsu", valid_out_lsu, vo);
            chk("ready_out_lsu", ready_out_lsu, !act);
            chk("arvalid", arvalid, act && m_kind == 1 && cyc <= na + m_ar);
            chk("rready",  rready,  act && m_kind == 1 && cyc >= na + m_ar + 1 && cyc <= na + m_ar + 1 + m_r);
            chk("awvalid", awvalid, act && m_kind == 2 && cyc <= na + m_aw);
            chk("wvalid",  wvalid,  act && m_kind == 2 && cyc <= na + m_w);
            chk("bready",  bready,  act && m_kind == 2 && cyc >= na + mx + 1 && cyc <= na + mx + 1 + m_b);
            chk("acc_fault", acc_fault, vo && m_fault);
            if (arvalid) chk("araddr", araddr, m_addr);
            if (awvalid) chk("awaddr", awaddr, m_addr);
            if (wvalid) begin
                chk("wdata", wdata, m_wdata);
                chk("wstrb", {28'h0, wstrb}, {28'h0, m_wstrb});
            end
            if (vo) begin
                chk("rdata_w",   rdata_w, m_rdw);
                chk("opcode_o",  {25'h0, opcode_o}, {25'h0, m_op});
                chk("pc_o",      pc_o, m_pc);
                chk("aluout_o",  aluout_o, m_alu);
                chk("gpr_wen_o", {31'h0, gpr_wen_o}, {31'h0, m_gpr});
                chk("rd_o",      {27'h0, rd_o}, {27'h0, m_rd});
                n_done++;
            end
        end
    end

    // ---------------- capture for literal checks ----------------
    int          cap_pulses;
    bit          cap_ar, cap_aw;
    logic [31:0] cap_rw, cap_alu, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_fault;
    always @(negedge clk) begin
        if (valid_out_lsu) begin
            cap_pulses++; cap_rw = rdata_w; cap_fault = acc_fault; cap_alu = aluout_o;
        end
        if (arvalid) cap_ar = 1;
        if (awvalid) cap_aw = 1;
        if (wvalid) begin cap_wdata = wdata; cap_wstrb = wstrb; end
    end

    task automatic clr_cap();
        cap_pulses = 0; cap_ar = 0; cap_aw = 0; cap_rw = 'x; cap_fault = 'x;
        cap_alu = 'x; cap_wdata = 'x; cap_wstrb = 'x;
    endtask

    task automatic rand_fields();
        opcode = 7'($urandom); funct3 = 3'($urandom); pc = $urandom; aluout = $urandom;
        store_data = $urandom; gpr_wen = 1'($urandom); rd = 5'($urandom);
    endtask

    task automatic start_txn(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input logic [31:0] rword, input logic [1:0] rr,
                             input logic [1:0] br, input int d_ar, input int d_r, input int d_aw,
                             input int d_w, input int d_b);
        int off, sz, mx;
        bit ld, stq, trap;
        @(posedge clk); #1;
        ld = (op == LD); stq = (op == ST); off = a % 4; sz = sz_of(ld, f3);
        trap = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (ld || stq) && ((sz == 2 && off % 2 == 1) || (sz == 4 && off != 0));
`endif
        m_kind = trap ? 3 : (ld ? 1 : (stq ? 2 : 0));
        m_ar = d_ar; m_r = d_r; m_aw = d_aw; m_w = d_w; m_b = d_b;
        s_rword = rword; s_rresp = rr; s_bresp = br;
        m_addr  = a & 32'hFFFF_FFFC;
        m_wdata = sd << (8 * off);
        m_wstrb = 4'h0;
        if (sz == 4) m_wstrb = 4'hF;
        else for (int i = 0; i < 4; i++) if (i >= off && i < off + sz) m_wstrb[i] = 1'b1;
        m_rdw   = (m_kind == 1) ? load_val(rword, f3, off) : 32'h0;
        m_fault = (m_kind == 3) || (m_kind == 1 && rr != 0) || (m_kind == 2 && br != 0);
        m_op = op; m_pc = $urandom; m_alu = a; m_gpr = 1'($urandom); m_rd = 5'($urandom);
        mx = (d_aw > d_w) ? d_aw : d_w;
        na = cyc + 1;
        done_at = (m_kind == 1) ? na + d_ar + d_r + 2 : ((m_kind == 2) ? na + mx + d_b + 2 : na);
        opcode = op; funct3 = f3; aluout = a; store_data = sd;
        pc = m_pc; gpr_wen = m_gpr; rd = m_rd;
        valid_in_exu = 1;
        n_start++;
        @(posedge clk); #1;
        valid_in_exu = 0;
        rand_fields();
    endtask

    task automatic wait_done();
        int n = 0;
        while ((n_start != n_done + n_abort) && n < 300) begin @(negedge clk); n++; end
        if (n_start != n_done + n_abort) begin
            chk("completion_timeout", 32'h0, 32'h1);
            n_abort++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 0; valid_in_exu = 0; rand_fields();
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rdata = 0; rresp = 0; bresp = 0;
        m_ar = 0; m_r = 0; m_aw = 0; m_w = 0; m_b = 0; na = 0; done_at = 0; m_kind = 0;
        clr_cap();
        repeat (3) @(posedge clk); #1;
        // reset state
        chk("rst_valid_out", {31'h0, valid_out_lsu}, 32'h0);
        chk("rst_busvalids", {27'h0, arvalid, rready, awvalid, wvalid, bready}, 32'h0);
        chk("rst_acc_fault", {31'h0, acc_fault}, 32'h0);
        chk("rst_aluout_o",  aluout_o, 32'h0);
        chk("rst_pc_o",      pc_o, 32'h0);
        chk("rst_rd_o",      {20'h0, opcode_o, rd_o}, 32'h0);
        chk("rst_rdata_w",   rdata_w, 32'h0);
        rst_n = 1;
        @(negedge clk);
        chk("ready_after_reset", {31'h0, ready_out_lsu}, 32'h1);
        chk_en = 1;

        // ALU op: one-cycle pass-through, no bus traffic
        clr_cap();
        start_txn(7'b0110011, 3'd0, 32'h10, 32'h0, 32'h0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        wait_done();
        chk("add_pulses", cap_pulses, 1);
        chk("add_aluout", cap_alu, 32'h10);
        chk("add_nobus", {30'h0, cap_ar, cap_aw}, 32'h0);

        // lb, top byte, arready late
        clr_cap();
        start_txn(LD, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_FF7F, 2'b00, 2'b00, 3, 0, 0, 0, 0);
        wait_done();
        chk("lb_rdata_w", cap_rw, 32'hFFFF_FF80);
        chk("lb_fault", {31'h0, cap_fault}, 32'h0);

        // sh, upper half, W before AW
        clr_cap();
        start_txn(ST, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h0, 2'b00, 2'b00, 0, 0, 2, 0, 1);
        wait_done();
        chk("sh_wdata", cap_wdata, 32'hABCD_0000);
        chk("sh_wstrb", {28'h0, cap_wstrb}, 32'hC);
        chk("sh_pulses", cap_pulses, 1);

        // lw with SLVERR
        clr_cap();
        start_txn(LD, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2'b10, 2'b00, 0, 1, 0, 0, 0);
        wait_done();
        chk("lw_err_fault", {31'h0, cap_fault}, 32'h1);

        // misaligned lw
        clr_cap();
        start_txn(LD, 3'b010, 32'h8000_0001, 32'h0, 32'h1122_3344, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        wait_done();
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_lw_noar", {31'h0, cap_ar}, 32'h0);
        chk("mis_lw_fault", {31'h0, cap_fault}, 32'h1);
        chk("mis_lw_rdata", cap_rw, 32'h0);
`else
        chk("mis_lw_ar", {31'h0, cap_ar}, 32'h1);
        chk("mis_lw_fault", {31'h0, cap_fault}, 32'h0);
        chk("mis_lw_rdata", cap_rw, 32'h0011_2233);
`endif

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            logic [6:0] op;
            int pick;
            pick = $urandom_range(0, 3);
            op = (pick == 0) ? LD : ((pick == 1) ? ST : 7'($urandom));
            start_txn(op, 3'($urandom), $urandom, $urandom, $urandom,
                      ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                      ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            wait_done();
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // reset while waiting in the read-data phase
        start_txn(LD, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 2'b00, 2'b00, 0, 6, 0, 0, 0);
        @(posedge clk); #1;
        chk("midrst_in_rdata", {31'h0, rready}, 32'h1);
        chk_en = 0;
        rst_n = 0;
        n_abort++;
        @(posedge clk); #1;
        chk("midrst_rready", {31'h0, rready}, 32'h0);
        chk("midrst_valid_out", {31'h0, valid_out_lsu}, 32'h0);
        chk("midrst_aluout_o", aluout_o, 32'h0);
        rst_n = 1;
        @(negedge clk);
        chk("midrst_ready_after", {31'h0, ready_out_lsu}, 32'h1);
        clr_cap();
        chk_en = 1;
        repeat (10) @(negedge clk);
        chk("midrst_no_pulse", cap_pulses, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
